// File: rtl/truth_table_scanner_pkg.sv
// Shared definitions for the truth-table scanner: FSM state encoding and code count.
package truth_table_scanner_pkg;

  localparam int unsigned SCAN_N_CODES = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// Settle-time counter: counts up while enabled, flags when SETTLE_CYCLES is reached.
module settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic       tc,
  output logic [3:0] count
);

  localparam logic [3:0] TC_VAL = 4'(SETTLE_CYCLES);

  logic [3:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 4'd0;
    end else if (en && (count_q != TC_VAL)) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc    = (count_q == TC_VAL);
  assign count = count_q;

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps a 3-input function stage through all codes, captures y per code and
// compares the assembled truth vector against a mask latched at start.
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned N_CODES       = SCAN_N_CODES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] expected,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth,
  output logic       match,
  output logic [3:0] mismatch_cnt,
  output logic [2:0] first_bad
);

  localparam logic [2:0] LAST_IDX = 3'(N_CODES - 1);

  state_e     state_d, state_q;
  logic [2:0] idx_d, idx_q;
  logic [7:0] exp_d, exp_q;
  logic [7:0] truth_d, truth_q;
  logic [3:0] cnt_d, cnt_q;
  logic [2:0] first_bad_d, first_bad_q;
  logic       match_d, match_q;

  logic       tmr_tc;
  logic [3:0] tmr_count;

  // Counter sits at zero outside HOLD, so every HOLD entry starts a fresh settle window.
  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q != ST_HOLD),
    .en   (state_q == ST_HOLD),
    .tc   (tmr_tc),
    .count(tmr_count)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    exp_d       = exp_q;
    truth_d     = truth_q;
    cnt_d       = cnt_q;
    first_bad_d = first_bad_q;
    match_d     = match_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          exp_d       = expected;
          truth_d     = 8'd0;
          idx_d       = 3'd0;
          cnt_d       = 4'd0;
          first_bad_d = 3'd0;
          match_d     = 1'b0;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tmr_tc) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        truth_d[idx_q] = y;
        if (exp_q[idx_q] != y) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd0) begin
            first_bad_d = idx_q;
          end
        end
        // match is resolved on the way into FINISH so it is valid alongside done.
        if (idx_q == LAST_IDX) begin
          match_d = (cnt_d == 4'd0);
          state_d = ST_FINISH;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = ST_HOLD;
        end
      end
      ST_FINISH: begin
        idx_d   = 3'd0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= 3'd0;
      exp_q       <= 8'd0;
      truth_q     <= 8'd0;
      cnt_q       <= 4'd0;
      first_bad_q <= 3'd0;
      match_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      exp_q       <= exp_d;
      truth_q     <= truth_d;
      cnt_q       <= cnt_d;
      first_bad_q <= first_bad_d;
      match_q     <= match_d;
    end
  end

  logic [2:0] code;
  assign code = (state_q == ST_IDLE) ? 3'd0 : idx_q;

  assign a            = code[2];
  assign b            = code[1];
  assign c            = code[0];
  assign busy         = (state_q == ST_HOLD) || (state_q == ST_SAMPLE);
  assign done         = (state_q == ST_FINISH);
  assign truth        = truth_q;
  assign match        = match_q;
  assign mismatch_cnt = cnt_q;
  assign first_bad    = first_bad_q;

  logic unused_ok;
  assign unused_ok = ^tmr_count;

endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
Self-contained sweep stage that sits directly upstream and downstream of a 3-input combinational function stage, such as the POS 4:1-mux stage.
- Drives that stage's a/b/c inputs through all 8 codes, 000 to 111.
- Waits a programmable settle time on each code, then registers the returned y.
- Assembles y into an 8-bit truth vector and compares it against an expected mask.
- Used on-chip and in benches to prove the function stage's minterm map without a reference model.

Parameters:
- SETTLE_CYCLES, default 1: extra cycles each code is held before y is sampled. Legal range 0..15.
- N_CODES, default 8: number of input codes, fixed at 2^3. Not meant to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a scan; sampled only in IDLE.
- expected  input  8  expected truth mask; bit i is the y expected for code i = {a,b,c}. Latched on start.
- a  output  1  drive to function stage; MSB of the current code.
- b  output  1  drive to function stage; middle bit of the current code.
- c  output  1  drive to function stage; LSB of the current code.
- y  input  1  response from the function stage.
- busy  output  1  high from the start edge until done.
- done  output  1  one-cycle pulse when a scan completes.
- truth  output  8  captured truth vector; bit i = y sampled for code i.
- match  output  1  truth == latched expected; valid from done onward.
- mismatch_cnt  output  4  number of differing bits, 0..8.
- first_bad  output  3  lowest mismatching code index; 0 when match=1.

Behaviour:
- Reset (rst=1 at an edge): state IDLE; a=b=c=0; busy=0; done=0; truth=0; match=0; mismatch_cnt=0; first_bad=0; internal index and settle counter 0.
  - Reset wins over every other input, including mid-scan; the scan is aborted and produces no done pulse.
- States: IDLE, HOLD, SAMPLE, FINISH.
- IDLE:
  - start=1 at the edge: latch expected, clear truth, idx=0, {a,b,c}=000, settle counter=0, busy=1, go to HOLD.
  - start=0: stay in IDLE. Previous results are held.
- HOLD:
  - {a,b,c} = idx, held stable.
  - Counter increments each cycle; when it equals SETTLE_CYCLES, go to SAMPLE.
  - SETTLE_CYCLES=0: HOLD lasts exactly 1 cycle.
- SAMPLE (1 cycle):
  - On the SAMPLE edge: truth[idx] <= y. If expected_l[idx] != y: mismatch_cnt += 1, and first_bad <= idx if this is the first miss.
  - idx != 7: idx += 1, drive the new code, counter=0, go to HOLD.
  - idx == 7: go to FINISH. a/b/c hold 111.
- Per-code cost: SETTLE_CYCLES + 2 cycles. Total scan: 8*(SETTLE_CYCLES+2) cycles from the start edge to FINISH entry.
- FINISH (1 cycle):
  - done=1; match=(mismatch_cnt==0); busy=0 on the next edge; return to IDLE.
  - {a,b,c} returns to 000 in IDLE.
- Results (truth, match, mismatch_cnt, first_bad) remain stable until the next accepted start.
  - On that start, they clear to 0 in the same edge.
- Ignored inputs:
  - start while busy is ignored.
  - A change to expected while busy is ignored, because only the latched copy is used.
- y is assumed combinational from a/b/c. It is registered only in SAMPLE and never earlier.
- Arithmetic:
  - idx: 3 bits, no wrap past 7.
  - mismatch_cnt: 4 bits; cannot exceed 8, so it never overflows.
- Simultaneous start and rst: reset takes priority.

Decomposition:
- Shared include (scanner_defs): state encodings (2 bits: IDLE=0, HOLD=1, SAMPLE=2, FINISH=3) and the N_CODES constant.
- One natural sub-module: settle_timer. It is a loadable up-counter with a terminal-count flag, parameterised by SETTLE_CYCLES, with synchronous clear.
- The FSM, capture and compare logic stay in truth_table_scanner.
- The function stage under test is instantiated beside the scanner in the wrapper or bench, never inside it.

Test Plan:
1. Reset, then idle 5 cycles → all outputs 0, busy=0, a/b/c=000.
2. SETTLE_CYCLES=1, function stage y=(a&~b&~c)|b, expected=8'hDC, pulse start.
   - busy high 24 cycles; codes step 0..7, each held 2 cycles then sampled.
   - done pulses once; truth=8'hDC, match=1, mismatch_cnt=0, first_bad=0.
3. Same DUT, expected=8'hDD → truth=8'hDC, match=0, mismatch_cnt=1, first_bad=0.
   - Then expected=8'h5C → mismatch_cnt=1, first_bad=7.
4. y tied to 0, expected=8'hFF → truth=8'h00, mismatch_cnt=8, first_bad=0, match=0.
5. Start pulsed again at cycle 10 of a scan, and expected changed mid-scan.
   - Both are ignored: a single done at the original time and results per the original mask.
   - rst asserted at cycle 12 → outputs zero on the next edge, no done; a new start then completes normally.
6. SETTLE_CYCLES=0 rebuild, test 2 stimulus → scan of 16 cycles, truth=8'hDC, match=1.
